// File: rtl/regfile_pkg.sv
// Shared definitions for the decode-stage register file.
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

  // Default geometry used by the decode stage.
  localparam int unsigned RF_DATA_W   = 32;
  localparam int unsigned RF_NUM_REGS = 32;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: walks every entry once after reset, then parks in READY.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = RF_NUM_REGS,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  output logic              o_busy,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  rf_state_t         r_state;
  rf_state_t         w_state_d;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_d;

  // State and counter register; reset restarts the walk from entry 0.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= RF_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Advance one entry per cycle; the counter holds its last value once READY.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      RF_CLEAR: begin
        if (r_cnt == LAST_ADDR) begin
          w_state_d = RF_READY;
        end else begin
          w_cnt_d = r_cnt + ADDR_W'(1);
        end
      end
      RF_READY: begin
        w_cnt_d = r_cnt;
      end
    endcase
  end

  assign o_busy     = (r_state == RF_CLEAR);
  // No entry is touched in a cycle where reset is asserted.
  assign o_clr_we   = o_busy && !i_reset;
  assign o_clr_addr = r_cnt;

endmodule

// File: rtl/multiport_register_file.sv
// Parametrised register file: N combinational read ports, one write port,
// optional hard-wired zero register and write-to-read bypass.
module multiport_register_file
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W     = RF_DATA_W,
  parameter int unsigned NUM_REGS   = RF_NUM_REGS,
  parameter int unsigned READ_PORTS = 2,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1,
  parameter int unsigned ADDR_W     = $clog2(NUM_REGS)
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_we,
  input  logic [ADDR_W-1:0]            i_waddr,
  input  logic [DATA_W-1:0]            i_wdata,
  input  logic [READ_PORTS*ADDR_W-1:0] i_raddr,
  output logic [READ_PORTS*DATA_W-1:0] o_rdata,
  output logic                         o_busy,
  input  logic [ADDR_W-1:0]            i_dbg_addr,
  output logic [DATA_W-1:0]            o_dbg_data
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_wr_ok;

  regfile_clear_fsm #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_clear_fsm (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .o_busy     (o_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  // A write lands only when READY, in range, and not aimed at the zero register.
  assign w_wr_ok = i_we && !o_busy && !i_reset &&
                   (32'(i_waddr) < NUM_REGS) &&
                   !((ZERO_REG != 0) && (i_waddr == '0));

  // Array update: clear sequence has the port while busy, then the pipeline write.
  always_ff @(posedge i_clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_ok) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read muxes: range check, zero register, bypass, then array, in that order.
  always_comb begin
    logic [ADDR_W-1:0] w_ra;
    w_ra    = '0;
    o_rdata = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      w_ra = i_raddr[p*ADDR_W +: ADDR_W];
      if (o_busy || (32'(w_ra) >= NUM_REGS)) begin
        o_rdata[p*DATA_W +: DATA_W] = '0;
      end else if ((ZERO_REG != 0) && (w_ra == '0)) begin
        o_rdata[p*DATA_W +: DATA_W] = '0;
      end else if ((BYPASS != 0) && w_wr_ok && (i_waddr == w_ra)) begin
        o_rdata[p*DATA_W +: DATA_W] = i_wdata;
      end else begin
        o_rdata[p*DATA_W +: DATA_W] = r_mem[w_ra];
      end
    end
  end

  // Debug port shows raw array content, never the bypassed value.
  always_comb begin
    o_dbg_data = '0;
    if (!o_busy && (32'(i_dbg_addr) < NUM_REGS)) begin
      o_dbg_data = r_mem[i_dbg_addr];
    end
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Self-checking bench: two instances (defaults, and 24x16 / 4 ports / no zero
// register / no bypass) against a behavioural model, plus directed literal checks.
module tb_multiport_register_file;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: defaults.
  logic        a_we;
  logic [4:0]  a_waddr;
  logic [31:0] a_wdata;
  logic [9:0]  a_raddr;
  logic [63:0] a_rdata;
  logic        a_busy;
  logic [4:0]  a_dbg_addr;
  logic [31:0] a_dbg_data;

  // Instance B: 24 regs, 16 bits, 4 ports, ZERO_REG=0, BYPASS=0.
  logic        b_we;
  logic [4:0]  b_waddr;
  logic [15:0] b_wdata;
  logic [19:0] b_raddr;
  logic [63:0] b_rdata;
  logic        b_busy;
  logic [4:0]  b_dbg_addr;
  logic [15:0] b_dbg_data;

  multiport_register_file u_dut_a (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_we       (a_we),
    .i_waddr    (a_waddr),
    .i_wdata    (a_wdata),
    .i_raddr    (a_raddr),
    .o_rdata    (a_rdata),
    .o_busy     (a_busy),
    .i_dbg_addr (a_dbg_addr),
    .o_dbg_data (a_dbg_data)
  );

  multiport_register_file #(
    .DATA_W     (16),
    .NUM_REGS   (24),
    .READ_PORTS (4),
    .ZERO_REG   (0),
    .BYPASS     (0)
  ) u_dut_b (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_we       (b_we),
    .i_waddr    (b_waddr),
    .i_wdata    (b_wdata),
    .i_raddr    (b_raddr),
    .o_rdata    (b_rdata),
    .o_busy     (b_busy),
    .i_dbg_addr (b_dbg_addr),
    .o_dbg_data (b_dbg_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem  [2][32];
  int          m_left [2];      // clear cycles still to run; 0 means ready
  bit          m_valid = 1'b0;

  function automatic int nregs(input int k);  return (k == 0) ? 32 : 24; endfunction
  function automatic int nports(input int k); return (k == 0) ? 2 : 4;   endfunction
  function automatic bit zreg(input int k);   return (k == 0);           endfunction
  function automatic bit byp(input int k);    return (k == 0);           endfunction

  function automatic logic cur_we(input int k);
    return (k == 0) ? a_we : b_we;
  endfunction
  function automatic int cur_wa(input int k);
    return (k == 0) ? int'(a_waddr) : int'(b_waddr);
  endfunction
  function automatic logic [31:0] cur_wd(input int k);
    return (k == 0) ? a_wdata : {16'h0, b_wdata};
  endfunction
  function automatic int cur_ra(input int k, input int p);
    return (k == 0) ? int'(a_raddr[p*5 +: 5]) : int'(b_raddr[p*5 +: 5]);
  endfunction
  function automatic int cur_dbg(input int k);
    return (k == 0) ? int'(a_dbg_addr) : int'(b_dbg_addr);
  endfunction
  function automatic logic [31:0] act_rd(input int k, input int p);
    return (k == 0) ? a_rdata[p*32 +: 32] : {16'h0, b_rdata[p*16 +: 16]};
  endfunction
  function automatic logic [31:0] act_dbg(input int k);
    return (k == 0) ? a_dbg_data : {16'h0, b_dbg_data};
  endfunction
  function automatic logic act_busy(input int k);
    return (k == 0) ? a_busy : b_busy;
  endfunction

  function automatic bit qual(input int k);
    return cur_we(k) && !rst && (m_left[k] == 0) && (cur_wa(k) < nregs(k)) &&
           !(zreg(k) && cur_wa(k) == 0);
  endfunction

  function automatic logic [31:0] exp_read(input int k, input int addr);
    if (m_left[k] != 0)                             return 32'h0;
    if (addr >= nregs(k))                           return 32'h0;
    if (zreg(k) && addr == 0)                       return 32'h0;
    if (byp(k) && qual(k) && cur_wa(k) == addr)     return cur_wd(k);
    return m_mem[k][addr];
  endfunction

  function automatic logic [31:0] exp_dbg(input int k);
    if (m_left[k] != 0 || cur_dbg(k) >= nregs(k)) return 32'h0;
    return m_mem[k][cur_dbg(k)];
  endfunction

  // Model state advance on each rising edge.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_left[k] <= nregs(k);
        for (int i = 0; i < 32; i++) m_mem[k][i] <= 32'h0;
      end else if (m_left[k] > 0) begin
        m_left[k] <= m_left[k] - 1;
      end else if (qual(k)) begin
        m_mem[k][cur_wa(k)] <= cur_wd(k);
      end
    end
    if (rst) m_valid <= 1'b1;
  end

  // Compare every cycle, mid-low-phase, after inputs have settled.
  always @(negedge clk) begin
    #2;
    if (m_valid) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("busy_%0d", k), {31'b0, act_busy(k)}, {31'b0, m_left[k] != 0});
        for (int p = 0; p < nports(k); p++) begin
          chk($sformatf("rdata_%0d_p%0d", k, p), act_rd(k, p), exp_read(k, cur_ra(k, p)));
        end
        chk($sformatf("dbg_%0d", k), act_dbg(k), exp_dbg(k));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    a_we = 1'b0; b_we = 1'b0;
  endtask

  // Count samples with busy high; optionally keep a write asserted early on.
  task automatic count_busy(input int we_cycles, output int na, output int nb);
    na = 0;
    nb = 0;
    a_we = (we_cycles > 0);
    b_we = (we_cycles > 0);
    for (int i = 0; i < 60; i++) begin
      if (a_busy) na++;
      if (b_busy) nb++;
      @(negedge clk);
      a_we = (i + 1 < we_cycles);
      b_we = (i + 1 < we_cycles);
      #1;
    end
  endtask

  int na, nb;

  initial begin
    rst = 1'b1;
    a_we = 0; a_waddr = 0; a_wdata = 0; a_raddr = 0; a_dbg_addr = 0;
    b_we = 0; b_waddr = 0; b_wdata = 0; b_raddr = 0; b_dbg_addr = 0;

    // Reset values and clear length.
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy_a", {31'b0, a_busy}, 32'd1);
    chk("rst_busy_b", {31'b0, b_busy}, 32'd1);
    chk("rst_rdata_a", a_rdata[31:0], 32'h0);
    chk("rst_dbg_a", a_dbg_data, 32'h0);
    count_busy(0, na, nb);
    chk("clear_len_a", na, 32);
    chk("clear_len_b", nb, 24);

    // All addresses read zero after the clear.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      a_raddr = {5'(31 - i), 5'(i)};
      a_dbg_addr = 5'(i);
      b_raddr = {4{5'(i)}};
      b_dbg_addr = 5'(i);
      #1;
      chk("sweep_a", a_rdata[31:0], 32'h0);
      chk("sweep_b", {16'h0, b_dbg_data}, 32'h0);
    end

    // Bypass on A, no bypass on B.
    @(negedge clk);
    a_we = 1; a_waddr = 5; a_wdata = 32'hDEADBEEF; a_raddr = 10'd5; a_dbg_addr = 5;
    b_we = 1; b_waddr = 5; b_wdata = 16'hBEEF; b_raddr = {4{5'd5}}; b_dbg_addr = 5;
    #1;
    chk("bypass_a", a_rdata[31:0], 32'hDEADBEEF);
    chk("dbg_pre_a", a_dbg_data, 32'h0);
    chk("nobypass_b", {16'h0, b_rdata[15:0]}, 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("dbg_post_a", a_dbg_data, 32'hDEADBEEF);
    chk("rd_post_b", {16'h0, b_rdata[15:0]}, 32'h0000BEEF);
    chk("dbg_post_b", {16'h0, b_dbg_data}, 32'h0000BEEF);

    // Register 0 behaviour.
    @(negedge clk);
    a_we = 1; a_waddr = 0; a_wdata = 32'h12345678; a_raddr = 10'd0; a_dbg_addr = 0;
    b_we = 1; b_waddr = 0; b_wdata = 16'h5678; b_raddr = 20'd0; b_dbg_addr = 0;
    #1;
    chk("zero_bypass_a", a_rdata[31:0], 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("zero_rd_a", a_rdata[31:0], 32'h0);
    chk("zero_dbg_a", a_dbg_data, 32'h0);
    chk("r0_rd_b", {16'h0, b_rdata[15:0]}, 32'h00005678);
    chk("r0_dbg_b", {16'h0, b_dbg_data}, 32'h00005678);

    // Top entry and out-of-range address on B.
    @(negedge clk);
    b_we = 1; b_waddr = 23; b_wdata = 16'hA5A5; b_raddr = {4{5'd23}};
    @(negedge clk);
    b_waddr = 30; b_wdata = 16'h1234;
    #1;
    for (int p = 0; p < 4; p++) chk("r23_b", {16'h0, b_rdata[p*16 +: 16]}, 32'h0000A5A5);
    @(negedge clk);
    idle();
    b_raddr = {4{5'd30}}; b_dbg_addr = 30;
    #1;
    chk("oor_rd_b", {16'h0, b_rdata[63:48]}, 32'h0);
    chk("oor_dbg_b", {16'h0, b_dbg_data}, 32'h0);

    // Reset reasserted mid-clear; writes while busy are ignored.
    @(negedge clk);
    a_we = 1; a_waddr = 3; a_wdata = 32'h11111111;
    b_we = 1; b_waddr = 3; b_wdata = 16'h1111;
    @(negedge clk);
    idle();
    rst = 1;
    @(negedge clk);
    rst = 0;
    repeat (10) @(negedge clk);
    rst = 1;
    #1;
    chk("midclear_busy_a", {31'b0, a_busy}, 32'd1);
    @(negedge clk);
    rst = 0;
    a_waddr = 3; a_wdata = 32'hFFFFFFFF; b_waddr = 3; b_wdata = 16'hFFFF;
    #1;
    count_busy(20, na, nb);
    chk("reclear_len_a", na, 32);
    chk("reclear_len_b", nb, 24);
    @(negedge clk);
    a_raddr = {5'd3, 5'd3}; a_dbg_addr = 3; b_raddr = {4{5'd3}}; b_dbg_addr = 3;
    #1;
    chk("r3_after_a", a_rdata[63:32], 32'h0);
    chk("r3_after_b", {16'h0, b_dbg_data}, 32'h0);

    // Fill, then reset in READY with a write presented in the reset cycle.
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      a_we = 1; a_waddr = 5'(i); a_wdata = 32'(i);
      b_we = 1; b_waddr = 5'(i); b_wdata = 16'(i);
    end
    @(negedge clk);
    idle();
    a_raddr = {5'd31, 5'd7};
    b_raddr = {5'd23, 5'd24, 5'd1, 5'd17};
    #1;
    chk("fill_r7_a", a_rdata[31:0], 32'd7);
    chk("fill_r31_a", a_rdata[63:32], 32'd31);
    chk("fill_r17_b", {16'h0, b_rdata[15:0]}, 32'd17);
    chk("fill_r24_b", {16'h0, b_rdata[47:32]}, 32'd0);
    @(negedge clk);
    rst = 1;
    a_we = 1; a_waddr = 9; a_wdata = 32'd99;
    @(negedge clk);
    rst = 0;
    idle();
    #1;
    count_busy(0, na, nb);
    chk("ready_reset_len_a", na, 32);
    chk("ready_reset_len_b", nb, 24);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      a_raddr = {5'(i), 5'(i)};
      a_dbg_addr = 5'(i);
      #1;
      chk("post_reset_a", a_rdata[31:0], 32'h0);
    end

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 249) == 0);
      a_we = 1'($urandom_range(0, 1));
      a_waddr = 5'($urandom_range(0, 31));
      a_wdata = $urandom;
      a_raddr = 10'($urandom);
      if ($urandom_range(0, 2) == 0) a_raddr[4:0] = a_waddr;
      a_dbg_addr = 5'($urandom);
      b_we = 1'($urandom_range(0, 1));
      b_waddr = 5'($urandom_range(0, 31));
      b_wdata = 16'($urandom);
      b_raddr = 20'($urandom);
      if ($urandom_range(0, 2) == 0) b_raddr[9:5] = b_waddr;
      b_dbg_addr = 5'($urandom);
    end

    @(negedge clk);
    rst = 0;
    idle();
    @(negedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiport_register_file.md
# multiport_register_file

Parametrised general-purpose register file for the instruction-decode stage. It is the successor to the fixed 32×32, two-read-port register database.
- Width, depth and read-port count are configurable.
- Register 0 can be hard-wired to zero.
- Write-to-read bypass is optional.
- Reset runs a sequential clear, one entry per cycle, with a busy flag the pipeline stalls on; there is no file-load on reset.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 32, number of registers (≥2, need not be a power of two)
- READ_PORTS, 2, number of independent combinational read ports (≥1)
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports
- ADDR_W, $clog2(NUM_REGS), derived; not overridden

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- raddr  in  READ_PORTS×ADDR_W  read addresses, one per port
- rdata  out  READ_PORTS×DATA_W  read data, one per port
- busy  out  1  high while the clear sequence runs; pipeline holds decode
- dbg_addr  in  ADDR_W  debug/observation read address
- dbg_data  out  DATA_W  raw array content at dbg_addr; no bypass applied

## Operation
- States: CLEAR and READY.
- Reset:
  - Reset high (any state, any cycle): state←CLEAR, clear counter←0. No array entry is written.
  - Reset held: state stays CLEAR with counter 0.
- CLEAR (reset low):
  - Each cycle writes 0 to mem[counter], then counter+1.
  - When counter==NUM_REGS−1 that entry is written and state←READY.
- busy = (state==CLEAR).
- While busy:
  - we is ignored.
  - rdata and dbg_data read 0 regardless of array contents.
- READY:
  - If we=1, waddr<NUM_REGS, and not (ZERO_REG && waddr==0): mem[waddr]←wdata at the rising edge.
  - All other writes are dropped silently.
- Read port i (combinational, READY), in priority order:
  1. raddr[i]≥NUM_REGS → 0.
  2. ZERO_REG && raddr[i]==0 → 0.
  3. BYPASS && write qualifies this cycle && waddr==raddr[i] → wdata.
  4. Otherwise → mem[raddr[i]].
- Multiple ports with equal addresses each receive the same value independently.
- dbg_data = mem[dbg_addr]; 0 if dbg_addr is out of range or busy.
- No arithmetic on data. The counter is ADDR_W bits wide, saturates at its final value and never wraps past NUM_REGS−1.

## Timing
- Reset values: busy=1; rdata=0 on all ports; dbg_data=0.
- Clear latency:
  - busy falls exactly NUM_REGS rising edges after the first edge with reset low.
  - The first write is accepted on the edge after busy is observed low.
- Reset mid-clear: the counter restarts from 0 and the full NUM_REGS cycles repeat. Partially cleared entries are irrelevant because reads are masked while busy.
- Reset in READY: contents are cleared again through CLEAR. Any write presented in the reset cycle is dropped.
- Write latency:
  - Write data is visible via the array on the cycle after the edge.
  - With BYPASS=1 it is also visible on rdata in the same cycle, zero latency.
  - With BYPASS=0 the same cycle returns the old value.
- Read latency: 0 cycles (combinational from raddr, and from we/waddr/wdata when BYPASS=1).

## Structure
- Shared package regfile_pkg holds:
  - rf_state_t enum {RF_CLEAR, RF_READY}
  - default-width constants RF_DATA_W=32 and RF_NUM_REGS=32, used by the decode stage.
- One sub-module, regfile_clear_fsm: state register plus clear counter. Outputs busy, clr_we and clr_addr.
- The top level owns the array, the write qualification, the read muxes with bypass, and the debug port.

## Test plan
- Reset 1 cycle, then idle, defaults → busy=1 for exactly 32 cycles, then 0. Reading all 32 addresses returns 0.
- Write 0xDEADBEEF to r5 with raddr[0]=5 in the same cycle → BYPASS=1: rdata[0]=0xDEADBEEF that cycle. BYPASS=0: old value that cycle, 0xDEADBEEF the next. dbg_data shows the new value only after the edge.
- Write 0x12345678 to r0 → ZERO_REG=1: rdata and dbg_data read 0. ZERO_REG=0: the value reads back.
- Reassert reset at clear count 10, release → busy stays high 32 further cycles. we=1 to r3 with 0xFFFFFFFF while busy → r3 reads 0 after clear.
- NUM_REGS=24, READ_PORTS=4, DATA_W=16: write 0xA5A5 to r23, read from all ports → all return 0xA5A5. Write to and read from address 30 → write dropped, read returns 0. Clear lasts 24 cycles.
- Reset in READY after filling r1..r31 with their index → 32 busy cycles, then all registers read 0.
